wb_port_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order pipeline's WB stage and a long-latency execution unit (LU, e.g. multiplier/divider). LU results wait in a small FIFO and are written when the pipeline leaves the port idle. A starvation counter forces a one-cycle pipeline stall so the LU result can drain. The block also keeps a per-register busy scoreboard for the hazard unit. It sits between the MEM/WB pipeline register's write-back mux, the LU result interface and the register file.

---
 rtl/wb_port_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB stage vs. long-latency unit result FIFO,
// with starvation-forced stall and a per-register outstanding-write scoreboard.
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid_i,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_wr_i,
    input  logic [31:0] pipe_wd_i,
    input  logic        lu_valid_i,
    input  logic [4:0]  lu_wr_i,
    input  logic [31:0] lu_wd_i,
    output logic        lu_ready_o,
    input  logic        lu_issue_i,
    input  logic [4:0]  lu_issue_rd_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_wr_o,
    output logic [31:0] rf_wd_o,
    output logic        stall_o,
    output logic [31:0] busy_mask_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    r_wr_mem [DEPTH];
    logic [31:0]   r_wd_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_busy;

    logic        w_pipe_req;
    logic        w_head_v;
    logic        w_force;
    logic        w_lu_gnt;
    logic        w_pipe_gnt;
    logic        w_push;
    logic [4:0]  w_head_wr;
    logic [31:0] w_head_wd;
    logic [31:0] w_busy_set;
    logic [31:0] w_busy_clr;

    assign w_pipe_req = pipe_valid_i & pipe_we_i & (pipe_wr_i != 5'd0);
    assign w_head_v   = (r_count != '0);
    assign w_force    = w_head_v & (r_starve == SW'(STARVE_MAX));
    assign w_lu_gnt   = w_force | (~w_pipe_req & w_head_v);
    assign w_pipe_gnt = w_pipe_req & ~w_force;
    assign w_head_wr  = r_wr_mem[r_rd_ptr];
    assign w_head_wd  = r_wd_mem[r_rd_ptr];

    assign lu_ready_o = ~rst & (r_count < CW'(DEPTH));
    // Destination x0 results are acknowledged but never enter the FIFO.
    assign w_push     = lu_valid_i & lu_ready_o & (lu_wr_i != 5'd0);
    assign stall_o    = ~rst & w_force;

    always_comb begin
        rf_we_o = 1'b0;
        rf_wr_o = '0;
        rf_wd_o = '0;
        if (!rst) begin
            if (w_lu_gnt) begin
                rf_we_o = 1'b1;
                rf_wr_o = w_head_wr;
                rf_wd_o = w_head_wd;
            end else if (w_pipe_gnt) begin
                rf_we_o = 1'b1;
                rf_wr_o = pipe_wr_i;
                rf_wd_o = pipe_wd_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wr_mem[r_wr_ptr] <= lu_wr_i;
            r_wd_mem[r_wr_ptr] <= lu_wd_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)   r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_lu_gnt) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_lu_gnt})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!w_head_v || w_lu_gnt) begin
            r_starve <= '0;
        end else if (w_pipe_gnt && (r_starve != SW'(STARVE_MAX))) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    assign w_busy_set = (lu_issue_i && (lu_issue_rd_i != 5'd0)) ? (32'd1 << lu_issue_rd_i) : '0;
    assign w_busy_clr = w_lu_gnt ? (32'd1 << w_head_wr) : '0;

    // Set is OR-ed in after the clear so a same-cycle reissue keeps the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
        end
    end

    assign busy_mask_o = r_busy;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid_i, pipe_we_i, lu_valid_i, lu_issue_i;
    logic [4:0]  pipe_wr_i, lu_wr_i, lu_issue_rd_i;
    logic [31:0] pipe_wd_i, lu_wd_i;
    logic        lu_ready_o, rf_we_o, stall_o;
    logic [4:0]  rf_wr_o;
    logic [31:0] rf_wd_o, busy_mask_o;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid_i(pipe_valid_i), .pipe_we_i(pipe_we_i),
        .pipe_wr_i(pipe_wr_i), .pipe_wd_i(pipe_wd_i),
        .lu_valid_i(lu_valid_i), .lu_wr_i(lu_wr_i), .lu_wd_i(lu_wd_i),
        .lu_ready_o(lu_ready_o),
        .lu_issue_i(lu_issue_i), .lu_issue_rd_i(lu_issue_rd_i),
        .rf_we_o(rf_we_o), .rf_wr_o(rf_wr_o), .rf_wd_o(rf_wd_o),
        .stall_o(stall_o), .busy_mask_o(busy_mask_o)
    );

    typedef struct {
        logic        pv, pwe;
        logic [4:0]  pwr;
        logic [31:0] pwd;
        logic        lv;
        logic [4:0]  lwr;
        logic [31:0] lwd;
        logic        iss;
        logic [4:0]  ird;
        logic        e_ready, e_we;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic        e_stall;
        logic [31:0] e_busy;
    } vec_t;

    typedef struct {
        logic [4:0]  wr;
        logic [31:0] wd;
    } ent_t;

    ent_t        q[$];
    int unsigned m_starve;
    logic [31:0] m_busy;

    logic        x_ready, x_we, x_stall, x_lu;
    logic [4:0]  x_wr;
    logic [31:0] x_wd;

    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(logic pv, logic [4:0] pwr, logic [31:0] pwd,
                                logic lv, logic [4:0] lwr, logic [31:0] lwd,
                                logic iss, logic [4:0] ird);
        vec_t v;
        v.pv = pv; v.pwe = pv; v.pwr = pwr; v.pwd = pwd;
        v.lv = lv; v.lwr = lwr; v.lwd = lwd; v.iss = iss; v.ird = ird;
        v.e_ready = 1'b0; v.e_we = 1'b0; v.e_wr = '0; v.e_wd = '0;
        v.e_stall = 1'b0; v.e_busy = '0;
        return v;
    endfunction

    function automatic vec_t ex(vec_t vi, logic rdy, logic we, logic [4:0] wr,
                                logic [31:0] wd, logic st, logic [31:0] busy);
        vec_t v = vi;
        v.e_ready = rdy; v.e_we = we; v.e_wr = wr; v.e_wd = wd;
        v.e_stall = st; v.e_busy = busy;
        return v;
    endfunction

    // Expected outputs from the queue model and the grant priority rules.
    task automatic model_expect();
        bit head_v, preq, frc;
        head_v = (q.size() != 0);
        preq   = pipe_valid_i && pipe_we_i && (pipe_wr_i != 0);
        frc    = head_v && (m_starve == SMAX);
        x_ready = (q.size() < DEPTH);
        x_stall = frc;
        x_lu    = frc || (!preq && head_v);
        x_we = 1'b0; x_wr = '0; x_wd = '0;
        if (x_lu) begin
            x_we = 1'b1; x_wr = q[0].wr; x_wd = q[0].wd;
        end else if (preq) begin
            x_we = 1'b1; x_wr = pipe_wr_i; x_wd = pipe_wd_i;
        end
    endtask

    task automatic model_update();
        bit head_v;
        ent_t e;
        head_v = (q.size() != 0);
        if (x_lu) begin
            m_busy[q[0].wr] = 1'b0;
            void'(q.pop_front());
        end
        if (!head_v || x_lu) m_starve = 0;
        else if (m_starve < SMAX) m_starve++;
        if (lu_valid_i && x_ready && lu_wr_i != 0) begin
            e.wr = lu_wr_i; e.wd = lu_wd_i;
            q.push_back(e);
        end
        if (lu_issue_i && lu_issue_rd_i != 0) m_busy[lu_issue_rd_i] = 1'b1;
    endtask

    task automatic compare(string name, logic rdy, logic we, logic [4:0] wr,
                           logic [31:0] wd, logic st, logic [31:0] busy);
        n_vec++;
        if (lu_ready_o !== rdy || rf_we_o !== we || rf_wr_o !== wr ||
            rf_wd_o !== wd || stall_o !== st || busy_mask_o !== busy) begin
            n_bad++;
            $display("FAIL %s t=%0t: got rdy=%b we=%b wr=%0d wd=%h stall=%b busy=%h; want rdy=%b we=%b wr=%0d wd=%h stall=%b busy=%h",
                     name, $time, lu_ready_o, rf_we_o, rf_wr_o, rf_wd_o, stall_o, busy_mask_o,
                     rdy, we, wr, wd, st, busy);
        end
    endtask

    task automatic step(input vec_t v, input bit chk_tbl, input string name);
        @(negedge clk);
        pipe_valid_i = v.pv; pipe_we_i = v.pwe; pipe_wr_i = v.pwr; pipe_wd_i = v.pwd;
        lu_valid_i = v.lv; lu_wr_i = v.lwr; lu_wd_i = v.lwd;
        lu_issue_i = v.iss; lu_issue_rd_i = v.ird;
        #1;
        model_expect();
        compare({name, "/model"}, x_ready, x_we, x_wr, x_wd, x_stall, m_busy);
        if (chk_tbl)
            compare({name, "/table"}, v.e_ready, v.e_we, v.e_wr, v.e_wd, v.e_stall, v.e_busy);
        @(posedge clk);
        model_update();
    endtask

    task automatic model_reset();
        q.delete();
        m_starve = 0;
        m_busy = '0;
    endtask

    vec_t tbl[11];
    vec_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = ex(mk(0, 0, 0,     0, 0, 0,          1, 5), 1, 0, 0, 0,          0, 32'h0);
        tbl[1]  = ex(mk(0, 0, 0,     1, 5, 32'h1234,   0, 0), 1, 0, 0, 0,          0, 32'h20);
        tbl[2]  = ex(mk(0, 0, 0,     0, 0, 0,          0, 0), 1, 1, 5, 32'h1234,   0, 32'h20);
        tbl[3]  = ex(mk(0, 0, 0,     0, 0, 0,          0, 0), 1, 0, 0, 0,          0, 32'h0);
        tbl[4]  = ex(mk(1, 1, 32'hA1, 1, 7, 32'h77,    1, 7), 1, 1, 1, 32'hA1,     0, 32'h0);
        tbl[5]  = ex(mk(1, 2, 32'hA2, 0, 0, 0,         0, 0), 1, 1, 2, 32'hA2,     0, 32'h80);
        tbl[6]  = ex(mk(1, 3, 32'hA3, 0, 0, 0,         0, 0), 1, 1, 3, 32'hA3,     0, 32'h80);
        tbl[7]  = ex(mk(1, 4, 32'hA4, 0, 0, 0,         0, 0), 1, 1, 4, 32'hA4,     0, 32'h80);
        tbl[8]  = ex(mk(1, 5, 32'hA5, 0, 0, 0,         0, 0), 1, 1, 5, 32'hA5,     0, 32'h80);
        tbl[9]  = ex(mk(1, 6, 32'hA6, 0, 0, 0,         0, 0), 1, 1, 7, 32'h77,     1, 32'h80);
        tbl[10] = ex(mk(1, 6, 32'hA6, 0, 0, 0,         0, 0), 1, 1, 6, 32'hA6,     0, 32'h0);

        rst = 1'b1;
        pipe_valid_i = 1; pipe_we_i = 1; pipe_wr_i = 3; pipe_wd_i = 32'hDEAD;
        lu_valid_i = 0; lu_wr_i = 0; lu_wd_i = 0; lu_issue_i = 0; lu_issue_rd_i = 0;
        model_reset();
        #2;
        compare("reset_hold", 0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

        // Three pushes with pipeline always writing: ready drops, order kept.
        begin
            int k = 0;
            for (int c = 0; c < 30 && !(k == 3 && q.size() == 0); c++) begin
                bit rdy_now;
                rdy_now = (q.size() < DEPTH);
                step(mk(1, 5'd10 + 5'(c % 8), 32'hB000 + c, k < 3, 5'd20 + 5'(k),
                        32'hC0 + k, 0, 0), 1'b0, "three_push");
                if (k < 3 && rdy_now) k++;
            end
            n_vec++;
            if (k != 3 || q.size() != 0) begin
                n_bad++;
                $display("FAIL three_push_drain: got pushed=%0d left=%0d, want pushed=3 left=0", k, q.size());
            end
        end

        // Same-cycle set and clear of busy[9]: set wins; rd=0 issue changes nothing.
        step(mk(0, 0, 0, 0, 0, 0, 1, 9), 1'b0, "iss9");
        step(mk(1, 1, 1, 1, 9, 32'h99, 0, 0), 1'b0, "push9");
        step(mk(0, 0, 0, 0, 0, 0, 1, 9), 1'b0, "grant9_reissue");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0), 1'b0, "busy9_kept");
        step(idle, 1'b0, "iss0_nochange");

        // Push and pop together at count=1 across pointer wraps.
        step(mk(0, 0, 0, 1, 3, 32'h300, 0, 0), 1'b0, "pp_fill");
        for (int i = 1; i <= 5; i++)
            step(mk(0, 0, 0, 1, 3, 32'h300 + i, 0, 0), 1'b0, $sformatf("pp%0d", i));
        step(idle, 1'b0, "pp_drain");
        step(idle, 1'b0, "pp_empty");

        // Reset with two queued entries and busy = 0x88.
        step(mk(0, 0, 0, 0, 0, 0, 1, 3), 1'b0, "r_iss3");
        step(mk(1, 1, 1, 1, 3, 32'h33, 1, 7), 1'b0, "r_push3");
        step(mk(1, 2, 2, 1, 7, 32'h77, 0, 0), 1'b0, "r_push7");
        step(mk(1, 4, 4, 0, 0, 0, 0, 0), 1'b0, "r_queued");
        @(negedge clk);
        pipe_valid_i = 1; pipe_we_i = 1; pipe_wr_i = 4;
        rst = 1'b1;
        #1;
        compare("rst_async", 0, 0, 0, 0, 0, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(idle, 1'b0, "post_rst");

        // Randomized traffic; a stalled WB instruction is re-presented.
        begin
            vec_t v;
            bit   held = 0;
            for (int c = 0; c < 1500; c++) begin
                if (!held) begin
                    v = mk($urandom_range(0, 99) < 60, 5'($urandom), $urandom,
                           $urandom_range(0, 99) < 40, 5'($urandom), $urandom,
                           $urandom_range(0, 99) < 30, 5'($urandom));
                    v.pwe = ($urandom_range(0, 9) != 0);
                end else begin
                    v.lv = $urandom_range(0, 1); v.lwr = 5'($urandom); v.lwd = $urandom;
                    v.iss = $urandom_range(0, 1); v.ird = 5'($urandom);
                end
                step(v, 1'b0, "rand");
                held = x_stall;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
